mac_share_sched: RTL and testbench
==================================

# mac_share_sched

Round-robin scheduler that shares one registered 3-stage multiply-accumulate pipeline between two operand requesters (switch-side port 0, button-side port 1). It arbitrates issue, tracks which requester owns each in-flight operation, maintains one accumulator per requester, and returns tagged results under a valid/ready handshake with full-pipeline stall. It sits between the board input conditioning and the result register/display logic.

## Interface
- `OP_W`, default 4: operand width for `a*_i` / `b*_i`.
- `ACC_W`, default 8: accumulator and result width; must satisfy `ACC_W >= 2*OP_W`.
- `clk` input, 1: sole clock; all logic on rising edge.
- `rst` input, 1: synchronous, active-high reset.
- `req0_i` input, 1: requester 0 has an operation pending.
- `a0_i`, `b0_i` input, OP_W each: requester 0 operands.
- `ack0_o` output, 1: combinational; requester 0 operation accepted this cycle.
- `req1_i`, `a1_i`, `b1_i`, `ack1_o`: same for requester 1.
- `clr_i` input, 2: bit i clears accumulator i at the next edge.
- `out_valid_o` output, 1: result present.
- `out_ready_i` input, 1: consumer accepts result.
- `out_id_o` output, 1: requester that owns the result.
- `out_data_o` output, ACC_W: new accumulator value for that requester.
- `acc0_o`, `acc1_o` output, ACC_W: current accumulator contents.

## Operation
- Pipeline: S1 registers `{id, a, b}`; S2 registers `prod = a*b`, zero-extended to ACC_W; S3/output registers `out_data = acc[id] + prod` (mod 2^ACC_W) and writes the same value to `acc[id]`.
- Stall: `stall = out_valid_o & ~out_ready_i`. While stalled, S1/S2/output hold, accumulators do not update, and both acks are 0.
- Arbitration (no stall): only one request -> grant it; both -> grant the requester not granted last; none -> S1 loads a bubble (valid 0). `last` pointer updates only on a grant.
- Acks are combinational from `req*_i`, `last`, and `stall`, and are one-hot or zero. Operands are sampled on the edge where ack is 1.
- Clear: `clr_i[i]` zeros `acc[i]` at the edge regardless of stall. If the same edge writes a result for id i, that result uses acc = 0 (`out_data = prod`, `acc[i] <= prod`); clear wins over the old value. Both bits may be set together.
- Output register: loads when not stalled. Its valid comes from S2 valid; a bubble gives `out_valid_o = 0`.
- Reset: all stage valids 0; `out_valid_o`, `out_id_o`, `out_data_o`, `acc0_o`, `acc1_o` = 0; `last` = 1, so requester 0 wins the first contest. Reset overrides stall and clear, and discards in-flight operations.

## Timing
- Throughput: one issue per cycle when `out_ready_i` is held high.
- Latency: an op accepted at edge k appears with `out_valid_o = 1` after edge k+2. It is dropped after the first edge where `out_ready_i = 1`.
- Back-to-back ops from the same id need no forwarding: the accumulate happens in the output stage, so the op at edge k+1 reads the value written at edge k+2 when it reaches S3 at edge k+3.
- A result held under stall keeps `out_id_o`/`out_data_o` stable until accepted.
- `acc*_o` change exactly on output-load edges and clear edges.

## Test plan
- **Single op:** reset, then req0 with a=3, b=5 for one cycle. Expect ack0 = 1 in that cycle, and after 3 edges out_valid = 1, id = 0, data = 15, acc0 = 15.
- **Contention:** req0 and req1 held high with a0=2, b0=2 and a1=3, b1=3 for 4 cycles. Expect grants 0,1,0,1 and outputs (0,4), (1,9), (0,8), (1,18).
- **Wrap:** OP_W=4, req0 with a=15, b=15 twice. Expect 225, then (225+225) mod 256 = 194.
- **Stall:** three back-to-back ops in flight, then out_ready=0 for 5 cycles. Expect the output held, acks 0, and no acc change. On release, results drain in order with none lost or duplicated.
- **Clear collision:** acc1 = 40, op (1, 4×4) at the output-load edge with clr_i=2'b10 on the same edge. Expect out_data = 16 and acc1 = 16.
- **Reset mid-flight:** rst=1 with 2 ops in flight and out_valid=1. Expect all outputs 0 the next cycle, no stale result afterwards, and requester 0 winning the first simultaneous request.

Source files
------------

// File: rtl/mac_share_sched.sv
// mac_share_sched: two requesters share one 3-stage multiply-accumulate
// pipeline. Round-robin issue, per-requester accumulators, tagged results
// returned under valid/ready with a full-pipeline stall.
module mac_share_sched #(
    parameter int OP_W  = 4,
    parameter int ACC_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_i,
    input  logic [OP_W-1:0]  a0_i,
    input  logic [OP_W-1:0]  b0_i,
    output logic             ack0_o,
    input  logic             req1_i,
    input  logic [OP_W-1:0]  a1_i,
    input  logic [OP_W-1:0]  b1_i,
    output logic             ack1_o,
    input  logic [1:0]       clr_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             out_id_o,
    output logic [ACC_W-1:0] out_data_o,
    output logic [ACC_W-1:0] acc0_o,
    output logic [ACC_W-1:0] acc1_o
);

    localparam int PROD_W = 2 * OP_W;

    // Stage registers
    logic              s1_valid_r;
    logic              s1_id_r;
    logic [OP_W-1:0]   s1_a_r;
    logic [OP_W-1:0]   s1_b_r;
    logic              s2_valid_r;
    logic              s2_id_r;
    logic [ACC_W-1:0]  s2_prod_r;
    logic              out_valid_r;
    logic              out_id_r;
    logic [ACC_W-1:0]  out_data_r;
    logic [ACC_W-1:0]  acc0_r;
    logic [ACC_W-1:0]  acc1_r;
    // Requester granted most recently; 1 after reset so requester 0 wins first
    logic              last_r;

    // Combinational helpers
    logic              stall_s;
    logic              grant0_s;
    logic              grant1_s;
    logic [PROD_W-1:0] mul_s;
    logic [ACC_W-1:0]  prod_s;
    logic [ACC_W-1:0]  acc_base_s;
    logic [ACC_W-1:0]  sum_s;
    logic              load_s;

    assign stall_s = out_valid_r & ~out_ready_i;
    assign load_s  = ~stall_s & s2_valid_r;
    assign ack0_o  = grant0_s;
    assign ack1_o  = grant1_s;

    // Round-robin arbitration; no grant while the pipeline is stalled
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (stall_s) begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end else if (req0_i && req1_i) begin
            grant0_s = last_r;
            grant1_s = ~last_r;
        end else if (req0_i) begin
            grant0_s = 1'b1;
        end else if (req1_i) begin
            grant1_s = 1'b1;
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    // Round-robin pointer moves only when something is granted
    always_ff @(posedge clk) begin
        if (rst) begin
            last_r <= 1'b1;
        end else if (grant0_s) begin
            last_r <= 1'b0;
        end else if (grant1_s) begin
            last_r <= 1'b1;
        end
    end

    // S1: capture owner id and operands of the granted request (bubble if none)
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_id_r    <= 1'b0;
            s1_a_r     <= {OP_W{1'b0}};
            s1_b_r     <= {OP_W{1'b0}};
        end else if (!stall_s) begin
            s1_valid_r <= grant0_s | grant1_s;
            s1_id_r    <= grant1_s;
            s1_a_r     <= grant1_s ? a1_i : a0_i;
            s1_b_r     <= grant1_s ? b1_i : b0_i;
        end
    end

    // Unsigned product, zero-extended to accumulator width
    always_comb begin
        mul_s                = {{OP_W{1'b0}}, s1_a_r} * {{OP_W{1'b0}}, s1_b_r};
        prod_s               = {ACC_W{1'b0}};
        prod_s[PROD_W-1:0]   = mul_s;
    end

    // S2: register the product with its owner tag
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_r <= 1'b0;
            s2_id_r    <= 1'b0;
            s2_prod_r  <= {ACC_W{1'b0}};
        end else if (!stall_s) begin
            s2_valid_r <= s1_valid_r;
            s2_id_r    <= s1_id_r;
            s2_prod_r  <= prod_s;
        end
    end

    // Accumulate against the owner's accumulator; a same-edge clear zeroes the base
    always_comb begin
        acc_base_s = {ACC_W{1'b0}};
        if (s2_id_r) begin
            acc_base_s = clr_i[1] ? {ACC_W{1'b0}} : acc1_r;
        end else begin
            acc_base_s = clr_i[0] ? {ACC_W{1'b0}} : acc0_r;
        end
        sum_s = acc_base_s + s2_prod_r;
    end

    // Output register: holds under stall; tag/data only replaced by a real result
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_id_r    <= 1'b0;
            out_data_r  <= {ACC_W{1'b0}};
        end else if (!stall_s) begin
            out_valid_r <= s2_valid_r;
            if (s2_valid_r) begin
                out_id_r   <= s2_id_r;
                out_data_r <= sum_s;
            end
        end
    end

    // Accumulators: written on output loads, cleared by clr_i even under stall
    always_ff @(posedge clk) begin
        if (rst) begin
            acc0_r <= {ACC_W{1'b0}};
            acc1_r <= {ACC_W{1'b0}};
        end else begin
            if (load_s && !s2_id_r) begin
                acc0_r <= sum_s;
            end else if (clr_i[0]) begin
                acc0_r <= {ACC_W{1'b0}};
            end
            if (load_s && s2_id_r) begin
                acc1_r <= sum_s;
            end else if (clr_i[1]) begin
                acc1_r <= {ACC_W{1'b0}};
            end
        end
    end

    assign out_valid_o = out_valid_r;
    assign out_id_o    = out_id_r;
    assign out_data_o  = out_data_r;
    assign acc0_o      = acc0_r;
    assign acc1_o      = acc1_r;

endmodule

// File: tb/tb_mac_share_sched.sv
// Directed, table-driven bench for mac_share_sched. Inputs change on the
// falling edge; acks are checked just after, registered outputs on the
// following falling edge.
module tb_mac_share_sched;

    localparam int OP_W  = 4;
    localparam int ACC_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0, req1;
    logic [OP_W-1:0]  a0, b0, a1, b1;
    logic             ack0, ack1;
    logic [1:0]       clr;
    logic             out_valid, out_ready, out_id;
    logic [ACC_W-1:0] out_data, acc0, acc1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic             r0;
        logic [OP_W-1:0]  a0, b0;
        logic             r1;
        logic [OP_W-1:0]  a1, b1;
        logic [1:0]       clr;
        logic             rdy;
        logic             eack0, eack1, evalid, eid;
        logic [ACC_W-1:0] edata, eacc0, eacc1;
    } vec_t;

    vec_t tbl[$];

    mac_share_sched #(.OP_W(OP_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst),
        .req0_i(req0), .a0_i(a0), .b0_i(b0), .ack0_o(ack0),
        .req1_i(req1), .a1_i(a1), .b1_i(b1), .ack1_o(ack1),
        .clr_i(clr),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_id_o(out_id), .out_data_o(out_data),
        .acc0_o(acc0), .acc1_o(acc1)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    function automatic vec_t mk(input int r0, input int xa0, input int xb0,
                                input int r1, input int xa1, input int xb1,
                                input int c, input int rdy,
                                input int ea0, input int ea1, input int ev,
                                input int eid, input int ed,
                                input int ec0, input int ec1);
        vec_t v;
        v.r0 = 1'(r0);  v.a0 = 4'(xa0); v.b0 = 4'(xb0);
        v.r1 = 1'(r1);  v.a1 = 4'(xa1); v.b1 = 4'(xb1);
        v.clr = 2'(c);  v.rdy = 1'(rdy);
        v.eack0 = 1'(ea0); v.eack1 = 1'(ea1); v.evalid = 1'(ev);
        v.eid = 1'(eid); v.edata = 8'(ed);
        v.eacc0 = 8'(ec0); v.eacc1 = 8'(ec1);
        return v;
    endfunction

    // idle cycle with consumer ready: no requests, optional clear
    function automatic vec_t idle(input int c, input int ev, input int eid,
                                  input int ed, input int ec0, input int ec1);
        return mk(0, 0, 0, 0, 0, 0, c, 1, 0, 0, ev, eid, ed, ec0, ec1);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string lbl);
        req0 = v.r0; a0 = v.a0; b0 = v.b0;
        req1 = v.r1; a1 = v.a1; b1 = v.b1;
        clr = v.clr; out_ready = v.rdy;
        #1;
        chk({lbl, ".ack0"}, 32'(ack0), 32'(v.eack0));
        chk({lbl, ".ack1"}, 32'(ack1), 32'(v.eack1));
        @(posedge clk);
        @(negedge clk);
        chk({lbl, ".valid"}, 32'(out_valid), 32'(v.evalid));
        if (v.evalid) begin
            chk({lbl, ".id"}, 32'(out_id), 32'(v.eid));
            chk({lbl, ".data"}, 32'(out_data), 32'(v.edata));
        end
        chk({lbl, ".acc0"}, 32'(acc0), 32'(v.eacc0));
        chk({lbl, ".acc1"}, 32'(acc1), 32'(v.eacc1));
    endtask

    task automatic chk_zero(input string lbl);
        chk({lbl, ".valid"}, 32'(out_valid), 32'd0);
        chk({lbl, ".id"},    32'(out_id),    32'd0);
        chk({lbl, ".data"},  32'(out_data),  32'd0);
        chk({lbl, ".acc0"},  32'(acc0),      32'd0);
        chk({lbl, ".acc1"},  32'(acc1),      32'd0);
    endtask

    initial begin
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        clr = 2'b00; out_ready = 1'b1;

        // Contention from reset: grants 0,1,0,1
        tbl.push_back(mk(1, 2, 2, 1, 3, 3, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 2, 2, 1, 3, 3, 0, 1, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 2, 2, 1, 3, 3, 0, 1, 1, 0, 1, 0, 4, 4, 0));
        tbl.push_back(mk(1, 2, 2, 1, 3, 3, 0, 1, 0, 1, 1, 1, 9, 4, 9));
        tbl.push_back(idle(0, 1, 0, 8, 8, 9));
        tbl.push_back(idle(0, 1, 1, 18, 8, 18));
        tbl.push_back(idle(3, 0, 0, 0, 0, 0));
        // Single op 3*5, result three edges after issue
        tbl.push_back(mk(1, 3, 5, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(idle(0, 0, 0, 0, 0, 0));
        tbl.push_back(idle(0, 1, 0, 15, 15, 0));
        tbl.push_back(idle(1, 0, 0, 0, 0, 0));
        // Wrap: 15*15 twice -> 225 then 194
        tbl.push_back(mk(1, 15, 15, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 15, 15, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(idle(0, 1, 0, 225, 225, 0));
        tbl.push_back(idle(0, 1, 0, 194, 194, 0));
        tbl.push_back(idle(0, 0, 0, 0, 194, 0));

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("row%0d", i));
        end

        // Stall: three ops in flight, consumer busy for 5 cycles
        apply(idle(3, 0, 0, 0, 0, 0), "stall.clr");
        apply(mk(0, 0, 0, 1, 1, 2, 0, 1, 0, 1, 0, 0, 0, 0, 0), "stall.t0");
        apply(mk(1, 2, 3, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0), "stall.t1");
        apply(mk(0, 0, 0, 1, 3, 3, 0, 1, 0, 1, 1, 1, 2, 0, 2), "stall.t2");
        for (int i = 0; i < 5; i++) begin
            apply(mk(1, 7, 7, 1, 7, 7, 0, 0, 0, 0, 1, 1, 2, 0, 2),
                  $sformatf("stall.hold%0d", i));
        end
        apply(idle(0, 1, 0, 6, 6, 2), "stall.drain0");
        apply(idle(0, 1, 1, 11, 6, 11), "stall.drain1");
        apply(idle(0, 0, 0, 0, 6, 11), "stall.empty0");
        apply(idle(0, 0, 0, 0, 6, 11), "stall.empty1");

        // Clear collides with an acc1 write: clear wins over the old value
        apply(idle(3, 0, 0, 0, 0, 0), "clrcol.clr");
        apply(mk(0, 0, 0, 1, 5, 8, 0, 1, 0, 1, 0, 0, 0, 0, 0), "clrcol.u0");
        apply(mk(0, 0, 0, 1, 4, 4, 0, 1, 0, 1, 0, 0, 0, 0, 0), "clrcol.u1");
        apply(idle(0, 1, 1, 40, 0, 40), "clrcol.u2");
        apply(idle(2, 1, 1, 16, 0, 16), "clrcol.u3");
        apply(idle(0, 0, 0, 0, 0, 16), "clrcol.u4");

        // Reset with two ops in flight and a valid result; last points at 0
        apply(mk(1, 1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 16), "rstmid.v0");
        apply(mk(1, 1, 2, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 16), "rstmid.v1");
        apply(mk(1, 1, 3, 0, 0, 0, 0, 1, 1, 0, 1, 0, 1, 1, 16), "rstmid.v2");
        req0 = 1'b0; req1 = 1'b0; clr = 2'b00; out_ready = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_zero("rstmid.rst");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            apply(idle(0, 0, 0, 0, 0, 0), $sformatf("rstmid.quiet%0d", i));
        end
        apply(mk(1, 1, 1, 1, 2, 2, 0, 1, 1, 0, 0, 0, 0, 0, 0), "rstmid.both");
        apply(mk(0, 0, 0, 1, 2, 2, 0, 1, 0, 1, 0, 0, 0, 0, 0), "rstmid.r1");
        apply(idle(0, 1, 0, 1, 1, 0), "rstmid.out0");
        apply(idle(0, 1, 1, 4, 1, 4), "rstmid.out1");
        apply(idle(0, 0, 0, 0, 1, 4), "rstmid.end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
